// File: rtl/raw_bus_bank_pkg.sv
// Shared constants for the raw operand bus bank and its per-channel FIFOs.
package raw_bus_bank_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int RAW_BUS_CH_MAX = 8;
  localparam int DEPTH_DEF      = 4;

  // Occupancy counter width for a given depth (counts 0..depth inclusive).
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/raw_bus_chan.sv
// One operand channel: DEPTH-entry FIFO with a hold register that keeps the
// last popped value visible while the channel is empty.
module raw_bus_chan
  import raw_bus_bank_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int CNT_W      = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  full,
  output logic [CNT_W-1:0]      count,
  output logic                  ovf
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] hold;
  logic                  ovf_q;
  logic                  pop_ok;
  logic                  push_ok;
  logic                  push_drop;

  assign valid = (cnt != '0);
  assign full  = (cnt == CNT_W'(DEPTH));
  assign count = cnt;
  assign ovf   = ovf_q;
  assign data  = valid ? mem[rd_ptr] : hold;

  // A pop frees the slot the simultaneous push needs, so full+pop still accepts.
  assign pop_ok    = !flush && rd_en && valid;
  assign push_ok   = !flush && wr_en && (!full || pop_ok);
  assign push_drop = !flush && wr_en && full && !pop_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      hold   <= '0;
      ovf_q  <= 1'b0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      hold   <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (pop_ok) begin
        hold   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (push_drop) begin
        ovf_q <= 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/raw_bus_bank.sv
// Bank of NUM_CH independent operand FIFOs sharing one write-data bus;
// per-channel outputs are packed onto flat vectors, channel k at slice k.
module raw_bus_bank
  import raw_bus_bank_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_CH     = 2,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            i_wr_en,
  input  logic [DATA_WIDTH-1:0]        i_data,
  input  logic [NUM_CH-1:0]            i_rd_en,
  input  logic [NUM_CH-1:0]            i_flush,
  output logic [NUM_CH*DATA_WIDTH-1:0] o_data,
  output logic [NUM_CH-1:0]            o_valid,
  output logic [NUM_CH-1:0]            o_full,
  output logic [NUM_CH*CNT_W-1:0]      o_count,
  output logic [NUM_CH-1:0]            o_ovf
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    raw_bus_chan #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (i_wr_en[k]),
      .wr_data (i_data),
      .rd_en   (i_rd_en[k]),
      .flush   (i_flush[k]),
      .data    (o_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .valid   (o_valid[k]),
      .full    (o_full[k]),
      .count   (o_count[k*CNT_W +: CNT_W]),
      .ovf     (o_ovf[k])
    );
  end

endmodule

// File: tb/tb_raw_bus_bank.sv
// Self-checking bench for raw_bus_bank (2 channels, depth 4, 8-bit data):
// directed vector table, mid-traffic reset, then random traffic against a queue model.
module tb_raw_bus_bank;

  localparam int DW = 8;
  localparam int NC = 2;
  localparam int DP = 4;
  localparam int CW = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NC-1:0]     i_wr_en = '0;
  logic [DW-1:0]     i_data = '0;
  logic [NC-1:0]     i_rd_en = '0;
  logic [NC-1:0]     i_flush = '0;
  logic [NC*DW-1:0]  o_data;
  logic [NC-1:0]     o_valid;
  logic [NC-1:0]     o_full;
  logic [NC*CW-1:0]  o_count;
  logic [NC-1:0]     o_ovf;

  int errors = 0;
  int checks = 0;

  raw_bus_bank #(.DATA_WIDTH(DW), .NUM_CH(NC), .DEPTH(DP), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr_en (i_wr_en),
    .i_data  (i_data),
    .i_rd_en (i_rd_en),
    .i_flush (i_flush),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_full  (o_full),
    .o_count (o_count),
    .o_ovf   (o_ovf)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per channel plus the last popped value.
  logic [DW-1:0] mq [NC][$];
  logic [DW-1:0] mhold [NC];
  logic          movf [NC];

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      mq[k].delete();
      mhold[k] = '0;
      movf[k]  = 1'b0;
    end
  endtask

  task automatic model_apply(input logic [NC-1:0] wr, input logic [NC-1:0] rd,
                             input logic [NC-1:0] fl, input logic [DW-1:0] d);
    for (int k = 0; k < NC; k++) begin
      if (fl[k]) begin
        mq[k].delete();
        mhold[k] = '0;
        movf[k]  = 1'b0;
      end else begin
        if (rd[k] && mq[k].size() > 0) mhold[k] = mq[k].pop_front();
        if (wr[k]) begin
          if (mq[k].size() < DP) mq[k].push_back(d);
          else movf[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ch%0d actual=%0h required=%0h", nm, k, act, exp);
    end
  endtask

  task automatic chk_chan(input string nm, input int k, input logic [DW-1:0] d,
                          input int cnt, input logic ovf);
    chk({nm, ".data"},  k, 32'(o_data[k*DW +: DW]), 32'(d));
    chk({nm, ".count"}, k, 32'(o_count[k*CW +: CW]), 32'(cnt));
    chk({nm, ".valid"}, k, 32'(o_valid[k]), 32'(cnt != 0));
    chk({nm, ".full"},  k, 32'(o_full[k]), 32'(cnt == DP));
    chk({nm, ".ovf"},   k, 32'(o_ovf[k]), 32'(ovf));
  endtask

  task automatic chk_model(input string nm);
    for (int k = 0; k < NC; k++) begin
      int sz;
      sz = mq[k].size();
      chk_chan(nm, k, (sz > 0) ? mq[k][0] : mhold[k], sz, movf[k]);
    end
  endtask

  // Drive at the negedge, clock once, sample at the following negedge.
  task automatic step(input logic [NC-1:0] wr, input logic [NC-1:0] rd,
                      input logic [NC-1:0] fl, input logic [DW-1:0] d);
    i_wr_en = wr; i_rd_en = rd; i_flush = fl; i_data = d;
    @(posedge clk);
    if (rst_n) model_apply(wr, rd, fl, d);
    else model_reset();
    @(negedge clk);
    i_wr_en = '0; i_rd_en = '0; i_flush = '0;
  endtask

  typedef struct {
    logic [NC-1:0] wr;
    logic [NC-1:0] rd;
    logic [NC-1:0] fl;
    logic [DW-1:0] d;
    logic [DW-1:0] d0;
    int            c0;
    logic          v0;
    logic [DW-1:0] d1;
    int            c1;
  } vec_t;

  vec_t vt [$];

  function automatic vec_t mk(input logic [NC-1:0] wr, input logic [NC-1:0] rd,
                              input logic [NC-1:0] fl, input logic [DW-1:0] d,
                              input logic [DW-1:0] d0, input int c0, input logic v0,
                              input logic [DW-1:0] d1, input int c1);
    vec_t v;
    v.wr = wr; v.rd = rd; v.fl = fl; v.d = d;
    v.d0 = d0; v.c0 = c0; v.v0 = v0; v.d1 = d1; v.c1 = c1;
    return v;
  endfunction

  initial begin
    // wr rd fl data | ch0: data count ovf | ch1: data count  (ch1 ovf always 0 here)
    vt.push_back(mk(2'b11, 2'b00, 2'b00, 8'hA1, 8'hA1, 1, 0, 8'hA1, 1)); // broadcast
    vt.push_back(mk(2'b00, 2'b01, 2'b00, 8'h00, 8'hA1, 0, 0, 8'hA1, 1)); // pop -> hold
    vt.push_back(mk(2'b01, 2'b00, 2'b00, 8'h10, 8'h10, 1, 0, 8'hA1, 1));
    vt.push_back(mk(2'b01, 2'b00, 2'b00, 8'h11, 8'h10, 2, 0, 8'hA1, 1));
    vt.push_back(mk(2'b01, 2'b00, 2'b00, 8'h12, 8'h10, 3, 0, 8'hA1, 1));
    vt.push_back(mk(2'b01, 2'b00, 2'b00, 8'h13, 8'h10, 4, 0, 8'hA1, 1)); // full
    vt.push_back(mk(2'b01, 2'b00, 2'b00, 8'h14, 8'h10, 4, 1, 8'hA1, 1)); // dropped
    vt.push_back(mk(2'b01, 2'b01, 2'b00, 8'h15, 8'h11, 4, 1, 8'hA1, 1)); // full push+pop
    vt.push_back(mk(2'b00, 2'b01, 2'b00, 8'h00, 8'h12, 3, 1, 8'hA1, 1));
    vt.push_back(mk(2'b00, 2'b01, 2'b00, 8'h00, 8'h13, 2, 1, 8'hA1, 1));
    vt.push_back(mk(2'b00, 2'b01, 2'b00, 8'h00, 8'h15, 1, 1, 8'hA1, 1));
    vt.push_back(mk(2'b00, 2'b01, 2'b00, 8'h00, 8'h15, 0, 1, 8'hA1, 1)); // drained
    vt.push_back(mk(2'b00, 2'b10, 2'b00, 8'h00, 8'h15, 0, 1, 8'hA1, 0));
    vt.push_back(mk(2'b10, 2'b00, 2'b00, 8'h20, 8'h15, 0, 1, 8'h20, 1));
    vt.push_back(mk(2'b10, 2'b10, 2'b00, 8'h21, 8'h15, 0, 1, 8'h21, 1)); // wrap run
    vt.push_back(mk(2'b10, 2'b10, 2'b00, 8'h22, 8'h15, 0, 1, 8'h22, 1));
    vt.push_back(mk(2'b10, 2'b10, 2'b00, 8'h23, 8'h15, 0, 1, 8'h23, 1));
    vt.push_back(mk(2'b10, 2'b10, 2'b00, 8'h24, 8'h15, 0, 1, 8'h24, 1));
    vt.push_back(mk(2'b10, 2'b10, 2'b00, 8'h25, 8'h15, 0, 1, 8'h25, 1));
    vt.push_back(mk(2'b10, 2'b00, 2'b00, 8'h26, 8'h15, 0, 1, 8'h25, 2));
    vt.push_back(mk(2'b00, 2'b10, 2'b00, 8'h00, 8'h15, 0, 1, 8'h26, 1));
    vt.push_back(mk(2'b01, 2'b00, 2'b00, 8'h30, 8'h30, 1, 1, 8'h26, 1));
    vt.push_back(mk(2'b01, 2'b00, 2'b00, 8'h31, 8'h30, 2, 1, 8'h26, 1));
    vt.push_back(mk(2'b01, 2'b00, 2'b00, 8'h32, 8'h30, 3, 1, 8'h26, 1));
    vt.push_back(mk(2'b01, 2'b01, 2'b01, 8'h33, 8'h00, 0, 0, 8'h26, 1)); // flush wins
    vt.push_back(mk(2'b01, 2'b01, 2'b00, 8'h40, 8'h40, 1, 0, 8'h26, 1)); // empty push+pop
    vt.push_back(mk(2'b00, 2'b01, 2'b00, 8'h00, 8'h40, 0, 0, 8'h26, 1));
    vt.push_back(mk(2'b00, 2'b00, 2'b10, 8'h00, 8'h40, 0, 0, 8'h00, 0)); // flush ch1
    vt.push_back(mk(2'b00, 2'b10, 2'b00, 8'h00, 8'h40, 0, 0, 8'h00, 0)); // pop empty
  end

  initial begin
    model_reset();
    @(negedge clk);
    rst_n = 1'b0;
    step('0, '0, '0, '0);
    step('0, '0, '0, '0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step('0, '0, '0, '0);
    for (int k = 0; k < NC; k++) chk_chan("reset_idle", k, '0, 0, 1'b0);

    for (int i = 0; i < vt.size(); i++) begin
      string nm;
      step(vt[i].wr, vt[i].rd, vt[i].fl, vt[i].d);
      nm = $sformatf("vec%0d", i);
      chk_chan(nm, 0, vt[i].d0, vt[i].c0, vt[i].v0);
      chk_chan(nm, 1, vt[i].d1, vt[i].c1, 1'b0);
    end

    // Mid-traffic reset with ch0 holding two entries.
    step(2'b01, 2'b00, 2'b00, 8'h55);
    step(2'b11, 2'b00, 2'b00, 8'h56);
    chk("pre_reset.count", 0, 32'(o_count[0 +: CW]), 32'd2);
    rst_n = 1'b0;
    step(2'b11, 2'b01, 2'b00, 8'h77);
    for (int k = 0; k < NC; k++) chk_chan("mid_reset", k, '0, 0, 1'b0);
    rst_n = 1'b1;
    step('0, '0, '0, '0);
    chk_model("post_reset");

    for (int i = 0; i < 400; i++) begin
      logic [NC-1:0] wr, rd, fl;
      wr = NC'($urandom_range(0, 3));
      rd = (i % 64 < 32) ? NC'($urandom_range(0, 3) & $urandom_range(0, 3))
                         : NC'($urandom_range(0, 3) | $urandom_range(0, 3));
      fl = '0;
      for (int k = 0; k < NC; k++) fl[k] = ($urandom_range(0, 19) == 0);
      step(wr, rd, fl, DW'($urandom));
      chk_model($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
